btree_switch3_rr: RTL and testbench

Parametrised three-port binary-tree NoC switch with top (child 0), bottom (child 1) and right (parent) ports. Each input has an in-RTL synchronous FIFO of configurable depth, replacing the vendor FIFO IP. Each output has a one-entry output register. Every output has its own round-robin arbiter whose pointer advances only on a grant. It is the drop-in building block for BTree levels of any width, depth and address range.

---
 rtl/btree_switch3_rr.sv | 247 ++++++++++++++++++++++++
 tb/tb_btree_switch3_rr.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btree_switch3_rr.sv
// -----------------------------------------------------------------------------
// btree_switch3_rr
//
// Three-port binary-tree NoC switch: top (child 0), bottom (child 1) and
// right (parent). Each input owns a small synchronous FIFO. Each output owns a
// one-entry output register and a round-robin arbiter whose pointer moves only
// when it grants.
//
// Port index N: 1 = top, 2 = bottom, 3 = right.
//   i_sclk          clock, rising edge
//   i_reset         asynchronous, active-high reset
//   i_dataN         input flit, destination in [DataWidth-1 -: AddrWidth]
//   i_data_validN   input flit valid
//   o_data_readyN   input FIFO can accept a flit (from registered count only)
//   o_dataN         output flit (registered)
//   o_data_validN   output flit valid (registered)
//   i_data_readyN   downstream accepts the output flit
//   o_stat_cntN     saturating count of flits delivered on output N
//
// Build option: define BTREE_SW_STATS_EN to generate the delivered-flit
// counters; without it o_stat_cntN is tied to zero.
// -----------------------------------------------------------------------------
module btree_switch3_rr #(
  parameter int DataWidth = 36,
  parameter int AddrWidth = 4,
  parameter int Depth     = 4,
  parameter int TopMin    = 1,
  parameter int TopMax    = 1,
  parameter int BottomMin = 0,
  parameter int BottomMax = 0,
  parameter int StatWidth = 16
) (
  input  logic                 i_sclk,
  input  logic                 i_reset,
  input  logic [DataWidth-1:0] i_data1,
  input  logic                 i_data_valid1,
  output logic                 o_data_ready1,
  input  logic [DataWidth-1:0] i_data2,
  input  logic                 i_data_valid2,
  output logic                 o_data_ready2,
  input  logic [DataWidth-1:0] i_data3,
  input  logic                 i_data_valid3,
  output logic                 o_data_ready3,
  output logic [DataWidth-1:0] o_data1,
  output logic                 o_data_valid1,
  input  logic                 i_data_ready1,
  output logic [DataWidth-1:0] o_data2,
  output logic                 o_data_valid2,
  input  logic                 i_data_ready2,
  output logic [DataWidth-1:0] o_data3,
  output logic                 o_data_valid3,
  input  logic                 i_data_ready3,
  output logic [StatWidth-1:0] o_stat_cnt1,
  output logic [StatWidth-1:0] o_stat_cnt2,
  output logic [StatWidth-1:0] o_stat_cnt3
);

  localparam int PtrWidth = $clog2(Depth);
  localparam int CntWidth = $clog2(Depth) + 1;
  localparam logic [CntWidth-1:0]  CntFull  = CntWidth'(Depth);
  localparam logic [AddrWidth-1:0] TopLo    = AddrWidth'(TopMin);
  localparam logic [AddrWidth-1:0] TopHi    = AddrWidth'(TopMax);
  localparam logic [AddrWidth-1:0] BotLo    = AddrWidth'(BottomMin);
  localparam logic [AddrWidth-1:0] BotHi    = AddrWidth'(BottomMax);

  // Inclusive range test done as one unsigned offset compare, so a range
  // starting at zero needs no always-true lower-bound comparison.
  function automatic logic dest_in_range(input logic [AddrWidth-1:0] dest,
                                         input logic [AddrWidth-1:0] lo,
                                         input logic [AddrWidth-1:0] hi);
    logic [AddrWidth-1:0] off_s;
    off_s = dest - lo;
    dest_in_range = (off_s <= (hi - lo));
  endfunction

  // Output index (0 top, 1 bottom, 2 right) for a destination. Anything
  // outside both child ranges goes right, including flits that came from right.
  function automatic logic [1:0] route_of(input logic [AddrWidth-1:0] dest);
    if (dest_in_range(dest, TopLo, TopHi)) begin
      route_of = 2'd0;
    end else if (dest_in_range(dest, BotLo, BotHi)) begin
      route_of = 2'd1;
    end else begin
      route_of = 2'd2;
    end
  endfunction

  logic [DataWidth-1:0] in_data_s    [3];
  logic [2:0]           in_valid_s;
  logic [2:0]           in_ready_s;
  logic [2:0]           out_ready_s;
  logic [DataWidth-1:0] head_s       [3];
  logic [2:0]           head_valid_s;
  logic [1:0]           head_route_s [3];
  logic [2:0]           pop_s;
  logic [2:0]           gnt_any_s;
  logic [1:0]           gnt_idx_s    [3];
  logic [DataWidth-1:0] gnt_data_s   [3];
  logic [DataWidth-1:0] out_data_r   [3];
  logic [2:0]           out_valid_r;
  // Arbiter pointers hold the 0-based index of the last granted input; the
  // reset value 2 (input 3) gives input 1 first priority.
  logic [1:0]           ptr_r        [3];

  assign in_data_s[0] = i_data1;
  assign in_data_s[1] = i_data2;
  assign in_data_s[2] = i_data3;
  assign in_valid_s   = {i_data_valid3, i_data_valid2, i_data_valid1};
  assign out_ready_s  = {i_data_ready3, i_data_ready2, i_data_ready1};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
      logic [DataWidth-1:0] mem_r [Depth];
      logic [PtrWidth-1:0]  wr_ptr_r;
      logic [PtrWidth-1:0]  rd_ptr_r;
      logic [CntWidth-1:0]  cnt_r;
      logic                 push_s;

      // Ready looks only at the registered count, so the pop side never
      // reaches it combinationally; it is forced low while reset is held.
      assign in_ready_s[gi]   = !i_reset && (cnt_r < CntFull);
      assign push_s           = in_valid_s[gi] && in_ready_s[gi];
      assign head_s[gi]       = mem_r[rd_ptr_r];
      assign head_valid_s[gi] = (cnt_r != {CntWidth{1'b0}});
      assign head_route_s[gi] = route_of(mem_r[rd_ptr_r][DataWidth-1 -: AddrWidth]);

      // FIFO storage write port (payload needs no reset)
      always_ff @(posedge i_sclk) begin
        if (push_s) begin
          mem_r[wr_ptr_r] <= in_data_s[gi];
        end
      end

      // FIFO pointers and occupancy; power-of-two depth makes the wrap natural
      always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
          wr_ptr_r <= {PtrWidth{1'b0}};
          rd_ptr_r <= {PtrWidth{1'b0}};
          cnt_r    <= {CntWidth{1'b0}};
        end else begin
          if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PtrWidth'(1);
          end
          if (pop_s[gi]) begin
            rd_ptr_r <= rd_ptr_r + PtrWidth'(1);
          end
          case ({push_s, pop_s[gi]})
            2'b10:   cnt_r <= cnt_r + CntWidth'(1);
            2'b01:   cnt_r <= cnt_r - CntWidth'(1);
            default: cnt_r <= cnt_r;
          endcase
        end
      end
    end
  endgenerate

  // Round-robin arbitration per output; each head requests exactly one
  // output, so an input can be popped by at most one grant per cycle.
  always_comb begin : p_arb
    logic [1:0] cand_s;
    cand_s = 2'd0;
    pop_s  = 3'b000;
    for (int o = 0; o < 3; o++) begin
      gnt_any_s[o]  = 1'b0;
      gnt_idx_s[o]  = 2'd0;
      gnt_data_s[o] = {DataWidth{1'b0}};
    end
    for (int o = 0; o < 3; o++) begin
      if (!out_valid_r[o] || out_ready_s[o]) begin
        for (int k = 1; k <= 3; k++) begin
          cand_s = 2'((int'(ptr_r[o]) + k) % 3);
          if (!gnt_any_s[o] && head_valid_s[cand_s] &&
              (head_route_s[cand_s] == 2'(o))) begin
            gnt_any_s[o]   = 1'b1;
            gnt_idx_s[o]   = cand_s;
            gnt_data_s[o]  = head_s[cand_s];
            pop_s[cand_s]  = 1'b1;
          end else begin
            gnt_any_s[o]   = gnt_any_s[o];
          end
        end
      end else begin
        gnt_any_s[o] = 1'b0;
      end
    end
  end

  // Output registers and arbiter pointers; data only changes on a grant,
  // which needs a free slot, so it is stable while valid and not ready.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      for (int o = 0; o < 3; o++) begin
        out_valid_r[o] <= 1'b0;
        out_data_r[o]  <= {DataWidth{1'b0}};
        ptr_r[o]       <= 2'd2;
      end
    end else begin
      for (int o = 0; o < 3; o++) begin
        if (gnt_any_s[o]) begin
          out_valid_r[o] <= 1'b1;
          out_data_r[o]  <= gnt_data_s[o];
          ptr_r[o]       <= gnt_idx_s[o];
        end else if (out_ready_s[o]) begin
          out_valid_r[o] <= 1'b0;
        end
      end
    end
  end

  assign o_data_ready1 = in_ready_s[0];
  assign o_data_ready2 = in_ready_s[1];
  assign o_data_ready3 = in_ready_s[2];
  assign o_data1       = out_data_r[0];
  assign o_data2       = out_data_r[1];
  assign o_data3       = out_data_r[2];
  assign o_data_valid1 = out_valid_r[0];
  assign o_data_valid2 = out_valid_r[1];
  assign o_data_valid3 = out_valid_r[2];

`ifdef BTREE_SW_STATS_EN
  logic [StatWidth-1:0] stat_r [3];

  // Delivered-flit counters, saturating at all ones
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      for (int o = 0; o < 3; o++) begin
        stat_r[o] <= {StatWidth{1'b0}};
      end
    end else begin
      for (int o = 0; o < 3; o++) begin
        if (out_valid_r[o] && out_ready_s[o] && (stat_r[o] != {StatWidth{1'b1}})) begin
          stat_r[o] <= stat_r[o] + StatWidth'(1);
        end
      end
    end
  end

  assign o_stat_cnt1 = stat_r[0];
  assign o_stat_cnt2 = stat_r[1];
  assign o_stat_cnt3 = stat_r[2];
`else
  assign o_stat_cnt1 = {StatWidth{1'b0}};
  assign o_stat_cnt2 = {StatWidth{1'b0}};
  assign o_stat_cnt3 = {StatWidth{1'b0}};
`endif

endmodule

// File: tb/tb_btree_switch3_rr.sv
// Directed self-checking bench for btree_switch3_rr (default parameters,
// StatWidth = 4 so counter saturation is reachable).
module tb_btree_switch3_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset = 1'b0;
  logic [35:0] i_data1 = 36'h0, i_data2 = 36'h0, i_data3 = 36'h0;
  logic        i_data_valid1 = 1'b0, i_data_valid2 = 1'b0, i_data_valid3 = 1'b0;
  logic        i_data_ready1 = 1'b1, i_data_ready2 = 1'b1, i_data_ready3 = 1'b1;
  logic        o_data_ready1, o_data_ready2, o_data_ready3;
  logic [35:0] o_data1, o_data2, o_data3;
  logic        o_data_valid1, o_data_valid2, o_data_valid3;
  logic [3:0]  o_stat_cnt1, o_stat_cnt2, o_stat_cnt3;

  btree_switch3_rr #(.StatWidth(4)) dut (
    .i_sclk(clk), .i_reset(i_reset),
    .i_data1(i_data1), .i_data_valid1(i_data_valid1), .o_data_ready1(o_data_ready1),
    .i_data2(i_data2), .i_data_valid2(i_data_valid2), .o_data_ready2(o_data_ready2),
    .i_data3(i_data3), .i_data_valid3(i_data_valid3), .o_data_ready3(o_data_ready3),
    .o_data1(o_data1), .o_data_valid1(o_data_valid1), .i_data_ready1(i_data_ready1),
    .o_data2(o_data2), .o_data_valid2(o_data_valid2), .i_data_ready2(i_data_ready2),
    .o_data3(o_data3), .o_data_valid3(o_data_valid3), .i_data_ready3(i_data_ready3),
    .o_stat_cnt1(o_stat_cnt1), .o_stat_cnt2(o_stat_cnt2), .o_stat_cnt3(o_stat_cnt3)
  );

`ifdef BTREE_SW_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  // Indexed views of the per-port signals (1 top, 2 bottom, 3 right)
  logic        ov   [1:3];
  logic [35:0] od   [1:3];
  logic        ordy [1:3];
  logic        ir   [1:3];
  logic [3:0]  st   [1:3];
  assign ov[1] = o_data_valid1;  assign ov[2] = o_data_valid2;  assign ov[3] = o_data_valid3;
  assign od[1] = o_data1;        assign od[2] = o_data2;        assign od[3] = o_data3;
  assign ordy[1] = o_data_ready1; assign ordy[2] = o_data_ready2; assign ordy[3] = o_data_ready3;
  assign ir[1] = i_data_ready1;  assign ir[2] = i_data_ready2;  assign ir[3] = i_data_ready3;
  assign st[1] = o_stat_cnt1;    assign st[2] = o_stat_cnt2;    assign st[3] = o_stat_cnt3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [35:0] in_q  [1:3][$];
  logic [35:0] out_q [1:3][$];
  int          out_t [1:3][$];
  int          hold_bad [1:3];
  logic        stall_v  [1:3];
  logic [35:0] stall_d  [1:3];
  logic        rdy_en   [1:3];
  logic        rdy_rnd  [1:3];

  // Flit layout: dest | 5A5 | src | seq | C3
  function automatic logic [35:0] mk(input logic [3:0] dest, input logic [3:0] src,
                                     input logic [7:0] seq);
    return {dest, 12'h5A5, src, seq, 8'hC3};
  endfunction

  task automatic clear_tb();
    for (int o = 1; o <= 3; o++) begin
      in_q[o].delete(); out_q[o].delete(); out_t[o].delete();
      hold_bad[o] = 0; stall_v[o] = 1'b0; stall_d[o] = 36'h0;
      rdy_en[o] = 1'b1; rdy_rnd[o] = 1'b0;
    end
  endtask

  // One clock cycle: drive queued flits and readies, log accepted inputs,
  // delivered outputs and hold violations, then advance past the edge.
  task automatic step();
    i_data_valid1 = (in_q[1].size() > 0); i_data1 = (in_q[1].size() > 0) ? in_q[1][0] : 36'h0;
    i_data_valid2 = (in_q[2].size() > 0); i_data2 = (in_q[2].size() > 0) ? in_q[2][0] : 36'h0;
    i_data_valid3 = (in_q[3].size() > 0); i_data3 = (in_q[3].size() > 0) ? in_q[3][0] : 36'h0;
    i_data_ready1 = rdy_en[1] && (!rdy_rnd[1] || ($urandom_range(0, 1) == 1));
    i_data_ready2 = rdy_en[2] && (!rdy_rnd[2] || ($urandom_range(0, 1) == 1));
    i_data_ready3 = rdy_en[3] && (!rdy_rnd[3] || ($urandom_range(0, 1) == 1));
    #1;
    if (i_data_valid1 && o_data_ready1) void'(in_q[1].pop_front());
    if (i_data_valid2 && o_data_ready2) void'(in_q[2].pop_front());
    if (i_data_valid3 && o_data_ready3) void'(in_q[3].pop_front());
    for (int o = 1; o <= 3; o++) begin
      if (stall_v[o] && (!ov[o] || (od[o] !== stall_d[o]))) hold_bad[o]++;
      stall_v[o] = ov[o] && !ir[o];
      stall_d[o] = od[o];
      if (ov[o] && ir[o]) begin
        out_q[o].push_back(od[o]);
        out_t[o].push_back(cyc);
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_data_valid1 = 1'b0; i_data_valid2 = 1'b0; i_data_valid3 = 1'b0;
    #3;
    @(negedge clk); i_reset = 1'b0;
    @(posedge clk); #1;
    clear_tb();
  endtask

  task automatic test_reset();
    #1 i_reset = 1'b1;
    #2;
    for (int o = 1; o <= 3; o++) begin
      checks++; if (ov[o] !== 1'b0) begin errors++; $display("FAIL reset_valid%0d got %b want 0", o, ov[o]); end
      checks++; if (od[o] !== 36'h0) begin errors++; $display("FAIL reset_data%0d got %h want 0", o, od[o]); end
      checks++; if (ordy[o] !== 1'b0) begin errors++; $display("FAIL reset_ready%0d got %b want 0", o, ordy[o]); end
      checks++; if (st[o] !== 4'h0) begin errors++; $display("FAIL reset_stat%0d got %0d want 0", o, st[o]); end
    end
    @(negedge clk); i_reset = 1'b0;
    @(posedge clk); #1;
    for (int o = 1; o <= 3; o++) begin
      checks++; if (ordy[o] !== 1'b1) begin errors++; $display("FAIL post_reset_ready%0d got %b want 1", o, ordy[o]); end
    end
    clear_tb();
  endtask

  task automatic test_single();
    logic [35:0] f;
    clear_tb();
    f = mk(4'd1, 4'd3, 8'h01);
    in_q[3].push_back(f);
    step();
    checks++; if (o_data_valid1 !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", o_data_valid1); end
    step();
    checks++; if (o_data_valid1 !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", o_data_valid1); end
    checks++; if (o_data1 !== f) begin errors++; $display("FAIL single_data got %h want %h", o_data1, f); end
    checks++; if (o_data_valid2 !== 1'b0) begin errors++; $display("FAIL single_v2 got %b want 0", o_data_valid2); end
    checks++; if (o_data_valid3 !== 1'b0) begin errors++; $display("FAIL single_v3 got %b want 0", o_data_valid3); end
    for (int n = 0; n < 3; n++) step();
    checks++; if (out_q[1].size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", out_q[1].size()); end
  endtask

  task automatic test_round_robin();
    int n;
    clear_tb();
    for (int s = 1; s <= 3; s++)
      for (int k = 0; k < 6; k++) in_q[s].push_back(mk(4'd7, 4'(s), 8'(k)));
    n = 0;
    while (out_q[3].size() < 18 && n < 60) begin step(); n++; end
    checks++; if (out_q[3].size() !== 18) begin errors++; $display("FAIL rr_count got %0d want 18", out_q[3].size()); end
    for (int j = 0; j < out_q[3].size(); j++) begin
      logic [35:0] e;
      e = mk(4'd7, 4'((j % 3) + 1), 8'(j / 3));
      checks++; if (out_q[3][j] !== e) begin errors++; $display("FAIL rr_order[%0d] got %h want %h", j, out_q[3][j], e); end
    end
    for (int j = 1; j < out_t[3].size(); j++) begin
      checks++; if (out_t[3][j] !== out_t[3][0] + j) begin errors++; $display("FAIL rr_gap[%0d] got cycle %0d want %0d", j, out_t[3][j], out_t[3][0] + j); end
    end
    checks++; if (out_q[1].size() + out_q[2].size() !== 0) begin errors++; $display("FAIL rr_stray got %0d want 0", out_q[1].size() + out_q[2].size()); end
  endtask

  task automatic test_backpressure();
    int n;
    clear_tb();
    rdy_en[2] = 1'b0;
    for (int k = 0; k < 6; k++) in_q[1].push_back(mk(4'd0, 4'd1, 8'(k)));
    for (int c = 0; c < 12; c++) step();
    checks++; if (in_q[1].size() !== 1) begin errors++; $display("FAIL bp_accepted got %0d want 5", 6 - in_q[1].size()); end
    checks++; if (o_data_ready1 !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", o_data_ready1); end
    checks++; if (o_data_valid2 !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", o_data_valid2); end
    checks++; if (o_data2 !== mk(4'd0, 4'd1, 8'd0)) begin errors++; $display("FAIL bp_head got %h want %h", o_data2, mk(4'd0, 4'd1, 8'd0)); end
    rdy_en[2] = 1'b1;
    n = 0;
    while (out_q[2].size() < 6 && n < 40) begin step(); n++; end
    checks++; if (out_q[2].size() !== 6) begin errors++; $display("FAIL bp_count got %0d want 6", out_q[2].size()); end
    for (int j = 0; j < out_q[2].size(); j++) begin
      checks++; if (out_q[2][j] !== mk(4'd0, 4'd1, 8'(j))) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", j, out_q[2][j], mk(4'd0, 4'd1, 8'(j))); end
    end
    checks++; if (hold_bad[2] !== 0) begin errors++; $display("FAIL bp_hold got %0d want 0", hold_bad[2]); end
  endtask

  task automatic test_toggle_ready();
    int n;
    int nxt [1:3];
    clear_tb();
    rdy_rnd[1] = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      nxt[s] = 0;
      for (int k = 0; k < 5; k++) in_q[s].push_back(mk(4'd1, 4'(s), 8'(k)));
    end
    n = 0;
    while (out_q[1].size() < 15 && n < 300) begin step(); n++; end
    checks++; if (out_q[1].size() !== 15) begin errors++; $display("FAIL tog_count got %0d want 15", out_q[1].size()); end
    for (int j = 0; j < out_q[1].size(); j++) begin
      int s;
      s = int'(out_q[1][j][19:16]);
      checks++;
      if (s < 1 || s > 3) begin
        errors++; $display("FAIL tog_src[%0d] got %0d want 1..3", j, s);
      end else begin
        if (out_q[1][j] !== mk(4'd1, 4'(s), 8'(nxt[s]))) begin
          errors++; $display("FAIL tog_order[%0d] got %h want %h", j, out_q[1][j], mk(4'd1, 4'(s), 8'(nxt[s])));
        end
        nxt[s]++;
      end
    end
    checks++; if (hold_bad[1] !== 0) begin errors++; $display("FAIL tog_hold got %0d want 0", hold_bad[1]); end
    rdy_rnd[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_tb();
    for (int k = 0; k < 6; k++) begin
      in_q[1].push_back(mk(4'd7, 4'd1, 8'(8'h10 + k)));
      in_q[2].push_back(mk(4'd1, 4'd2, 8'(8'h20 + k)));
    end
    for (int c = 0; c < 4; c++) step();
    #2 i_reset = 1'b1;
    i_data_valid1 = 1'b0; i_data_valid2 = 1'b0; i_data_valid3 = 1'b0;
    #1;
    for (int o = 1; o <= 3; o++) begin
      checks++; if (ov[o] !== 1'b0) begin errors++; $display("FAIL mid_valid%0d got %b want 0", o, ov[o]); end
      checks++; if (ordy[o] !== 1'b0) begin errors++; $display("FAIL mid_ready%0d got %b want 0", o, ordy[o]); end
      checks++; if (od[o] !== 36'h0) begin errors++; $display("FAIL mid_data%0d got %h want 0", o, od[o]); end
    end
    @(posedge clk); #3;
    checks++; if (o_data_valid3 !== 1'b0) begin errors++; $display("FAIL mid_hold_valid got %b want 0", o_data_valid3); end
    @(negedge clk); i_reset = 1'b0;
    @(posedge clk); #1;
    clear_tb();
    for (int c = 0; c < 10; c++) step();
    checks++; if (out_q[1].size() + out_q[2].size() + out_q[3].size() !== 0) begin
      errors++; $display("FAIL mid_stale got %0d want 0", out_q[1].size() + out_q[2].size() + out_q[3].size());
    end
    in_q[3].push_back(mk(4'd1, 4'd3, 8'h77));
    for (int c = 0; c < 5; c++) step();
    checks++; if (out_q[1].size() !== 1) begin errors++; $display("FAIL mid_fresh_count got %0d want 1", out_q[1].size()); end
    else begin
      checks++; if (out_q[1][0] !== mk(4'd1, 4'd3, 8'h77)) begin errors++; $display("FAIL mid_fresh_data got %h want %h", out_q[1][0], mk(4'd1, 4'd3, 8'h77)); end
    end
  endtask

  task automatic test_stats();
    int n;
    do_reset();
    for (int k = 0; k < 20; k++) in_q[1].push_back(mk(4'd0, 4'd1, 8'(k)));
    n = 0;
    while (out_q[2].size() < 7 && n < 50) begin step(); n++; end
    checks++; if (o_stat_cnt2 !== (StatsOn ? 4'd7 : 4'd0)) begin errors++; $display("FAIL stat_mid got %0d want %0d", o_stat_cnt2, StatsOn ? 7 : 0); end
    while (out_q[2].size() < 20 && n < 100) begin step(); n++; end
    checks++; if (out_q[2].size() !== 20) begin errors++; $display("FAIL stat_delivered got %0d want 20", out_q[2].size()); end
    checks++; if (o_stat_cnt2 !== (StatsOn ? 4'd15 : 4'd0)) begin errors++; $display("FAIL stat_sat got %0d want %0d", o_stat_cnt2, StatsOn ? 15 : 0); end
    checks++; if (o_stat_cnt1 !== 4'd0) begin errors++; $display("FAIL stat_cnt1 got %0d want 0", o_stat_cnt1); end
    checks++; if (o_stat_cnt3 !== 4'd0) begin errors++; $display("FAIL stat_cnt3 got %0d want 0", o_stat_cnt3); end
  endtask

  initial begin
    clear_tb();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_toggle_ready();
    test_reset_mid();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
